// File: rtl/trigger_capture.sv
// Trigger-and-capture block: waits for a ch6..ch8 pattern or a ch8 falling edge,
// records DEPTH samples of {ch3, ch4}, then replays them over a valid/ready port.
module trigger_capture #(
    parameter int         DEPTH        = 9,
    parameter logic [2:0] PATTERN      = 3'b101,
    parameter int         EDGE_HOLDOFF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       mode,
    input  logic [2:0] trig_in,
    input  logic [1:0] data_in,
    output logic       rd_valid,
    output logic [1:0] rd_data,
    output logic       rd_last,
    input  logic       rd_ready,
    output logic       busy,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    localparam int              PW        = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_IDX  = PW'(DEPTH - 1);
    localparam logic [3:0]      HOLD_LAST = 4'(EDGE_HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLDOFF,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_modeQ;
    logic            r_trigPrev;
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [3:0]      r_holdCnt;
    logic [1:0]      r_buf [DEPTH];
    logic            r_rdValid;
    logic [1:0]      r_rdData;
    logic            r_rdLast;
    logic            r_ledR;
    logic            r_ledG;
    logic            r_ledB;

    logic            w_trigger;
    logic            w_armAccept;
    logic            w_rdXfer;
    logic [PW-1:0]   w_rdNext;

    assign w_trigger   = r_modeQ ? (r_trigPrev & ~trig_in[0]) : (trig_in == PATTERN);
    assign w_armAccept = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rdXfer    = (r_state == S_DONE) && r_rdValid && rd_ready;
    assign w_rdNext    = r_rdPtr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // arm in DONE outranks a same-cycle read transfer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) w_nextState = S_ARMED;
            end
            S_ARMED: begin
                if (w_trigger) begin
                    if (r_modeQ && (EDGE_HOLDOFF != 0)) w_nextState = S_HOLDOFF;
                    else                                w_nextState = S_CAPTURE;
                end
            end
            S_HOLDOFF: begin
                if (r_holdCnt == HOLD_LAST) w_nextState = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_wrPtr == LAST_IDX) w_nextState = S_DONE;
            end
            S_DONE: begin
                if (arm)                       w_nextState = S_ARMED;
                else if (w_rdXfer && r_rdLast) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            r_buf[r_wrPtr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_modeQ    <= 1'b0;
            r_trigPrev <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_holdCnt  <= '0;
            r_rdValid  <= 1'b0;
            r_rdData   <= '0;
            r_rdLast   <= 1'b0;
            r_ledR     <= 1'b0;
            r_ledG     <= 1'b0;
            r_ledB     <= 1'b0;
        end else begin
            r_ledR <= (w_nextState == S_ARMED);
            r_ledB <= (w_nextState == S_HOLDOFF) || (w_nextState == S_CAPTURE);
            r_ledG <= (w_nextState == S_DONE);
            if (w_armAccept) begin
                r_modeQ    <= mode;
                r_trigPrev <= trig_in[0];
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_holdCnt  <= '0;
                r_rdValid  <= 1'b0;
                r_rdData   <= '0;
                r_rdLast   <= 1'b0;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        r_trigPrev <= trig_in[0];
                        r_holdCnt  <= '0;
                    end
                    S_HOLDOFF: begin
                        r_holdCnt <= r_holdCnt + 1'b1;
                    end
                    S_CAPTURE: begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                        // Entry 0 is still being written on this edge when DEPTH is 1.
                        if (r_wrPtr == LAST_IDX) begin
                            r_rdPtr   <= '0;
                            r_rdValid <= 1'b1;
                            r_rdData  <= (DEPTH == 1) ? data_in : r_buf[0];
                            r_rdLast  <= (DEPTH == 1);
                        end
                    end
                    S_DONE: begin
                        if (w_rdXfer) begin
                            if (r_rdLast) begin
                                r_rdValid <= 1'b0;
                                r_rdLast  <= 1'b0;
                                r_rdData  <= '0;
                            end else begin
                                r_rdPtr  <= w_rdNext;
                                r_rdData <= r_buf[w_rdNext];
                                r_rdLast <= (w_rdNext == LAST_IDX);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_valid = r_rdValid;
    assign rd_data  = r_rdData;
    assign rd_last  = r_rdLast;
    assign busy     = (r_state != S_IDLE);
    assign led_r    = r_ledR;
    assign led_g    = r_ledG;
    assign led_b    = r_ledB;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: fixed vector table, directed scenarios,
// and randomized traffic against a queue-based behavioural model.
module tb_trigger_capture;

    localparam int         DEPTH   = 9;
    localparam logic [2:0] PATTERN = 3'b101;
    localparam int         HOLD    = 1;

    localparam int P_IDLE = 0, P_ARMED = 1, P_HOLD = 2, P_CAPT = 3, P_DONE = 4;

    logic       clk = 1'b0;
    logic       rst, arm, mode, rd_ready;
    logic [2:0] trig_in;
    logic [1:0] data_in;
    logic       rd_valid, rd_last, busy, led_r, led_g, led_b;
    logic [1:0] rd_data;

    always #5 clk = ~clk;

    trigger_capture #(
        .DEPTH(DEPTH), .PATTERN(PATTERN), .EDGE_HOLDOFF(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig_in(trig_in),
        .data_in(data_in), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rd_ready(rd_ready), .busy(busy), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Model: a phase, a sample queue and a read index.
    int         mPhase = P_IDLE;
    logic       mMode  = 1'b0;
    logic       mPrev  = 1'b0;
    int         holdLeft = 0;
    logic [1:0] capQ[$];
    int         readIdx = 0;

    // Values handed over by the DUT, recorded for the directed scenarios.
    logic [1:0] readQ[$];
    logic       lastQ[$];

    typedef struct {
        logic       rst, arm, mode;
        logic [2:0] trig;
        logic [1:0] data;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    task automatic modelArm(input logic m, input logic t0);
        mPhase  = P_ARMED;
        mMode   = m;
        mPrev   = t0;
        readIdx = 0;
        capQ.delete();
    endtask

    task automatic modelStep(input logic r, input logic a, input logic m,
                             input logic [2:0] t, input logic [1:0] d, input logic rdy);
        logic hit;
        if (r) begin
            mPhase = P_IDLE; mMode = 1'b0; mPrev = 1'b0;
            holdLeft = 0; readIdx = 0; capQ.delete();
        end else begin
            case (mPhase)
                P_IDLE: if (a) modelArm(m, t[0]);
                P_ARMED: begin
                    hit   = mMode ? (mPrev && !t[0]) : (t == PATTERN);
                    mPrev = t[0];
                    if (hit) begin
                        capQ.delete();
                        if (mMode && HOLD > 0) begin mPhase = P_HOLD; holdLeft = HOLD; end
                        else mPhase = P_CAPT;
                    end
                end
                P_HOLD: begin
                    holdLeft--;
                    if (holdLeft == 0) mPhase = P_CAPT;
                end
                P_CAPT: begin
                    capQ.push_back(d);
                    if (capQ.size() == DEPTH) begin mPhase = P_DONE; readIdx = 0; end
                end
                P_DONE: begin
                    if (a) modelArm(m, t[0]);
                    else if (rdy) begin
                        readIdx++;
                        if (readIdx == DEPTH) mPhase = P_IDLE;
                    end
                end
                default: mPhase = P_IDLE;
            endcase
        end
    endtask

    // {busy, rd_valid, rd_data[1:0], rd_last, led_r, led_g, led_b}
    function automatic logic [7:0] modelOut();
        logic       v;
        logic [1:0] dd;
        v  = (mPhase == P_DONE);
        dd = v ? capQ[readIdx] : 2'b00;
        return {mPhase != P_IDLE, v, dd, v && (readIdx == DEPTH - 1),
                mPhase == P_ARMED, mPhase == P_DONE, (mPhase == P_HOLD) || (mPhase == P_CAPT)};
    endfunction

    function automatic logic [7:0] dutOut();
        return {busy, rd_valid, rd_data, rd_last, led_r, led_g, led_b};
    endfunction

    task automatic compareVal(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string name);
        compareVal(name, int'(dutOut()), int'(modelOut()));
    endtask

    // Drive one cycle of inputs, clock it into the DUT and the model, check #1 later.
    task automatic applyStimulus(input string name, input logic r, input logic a, input logic m,
                                 input logic [2:0] t, input logic [1:0] d, input logic rdy);
        logic       xfer;
        logic [1:0] xData;
        logic       xLast;
        rst = r; arm = a; mode = m; trig_in = t; data_in = d; rd_ready = rdy;
        xfer  = rd_valid && rdy && !a && !r;
        xData = rd_data;
        xLast = rd_last;
        @(posedge clk);
        modelStep(r, a, m, t, d, rdy);
        if (xfer) begin readQ.push_back(xData); lastQ.push_back(xLast); end
        #1;
        checkOutput(name);
    endtask

    task automatic drain(input string name, input bit backpressure, input int budget);
        int  i;
        logic rdy;
        i = 0;
        while (mPhase != P_IDLE && i < budget) begin
            rdy = backpressure ? ((i % 3) == 0) : 1'b1;
            applyStimulus(name, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, rdy);
            i++;
        end
        if (mPhase != P_IDLE) compareVal({name, "_timeout"}, int'(busy), 0);
    endtask

    task automatic checkReadout(input string name, input logic [1:0] want[DEPTH]);
        compareVal({name, "_count"}, readQ.size(), DEPTH);
        for (int k = 0; k < readQ.size() && k < DEPTH; k++) begin
            compareVal($sformatf("%s_data%0d", name, k), int'(readQ[k]), int'(want[k]));
            compareVal($sformatf("%s_last%0d", name, k), int'(lastQ[k]), int'(k == DEPTH - 1));
        end
    endtask

    initial begin
        vec_t       vecs[8];
        logic [1:0] want[DEPTH];
        int         ledBCount;

        rst = 1'b1; arm = 1'b0; mode = 1'b0; trig_in = '0; data_in = '0; rd_ready = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 8'b0000_0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 8'b1000_0100};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 8'b1000_0100};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 3'b011, 2'b00, 1'b0, 8'b1000_0100};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0, 8'b1000_0001};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0, 8'b1000_0001};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 8'b0000_0000};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0, 8'b0000_0000};

        for (int v = 0; v < 8; v++) begin
            applyStimulus($sformatf("vec%0d_model", v), vecs[v].rst, vecs[v].arm, vecs[v].mode,
                          vecs[v].trig, vecs[v].data, vecs[v].rdy);
            compareVal($sformatf("vec%0d_table", v), int'(dutOut()), int'(vecs[v].exp));
        end

        // Pattern trigger with a 00,01,10,11 data ramp.
        applyStimulus("pat_rst", 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        applyStimulus("pat_arm", 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus("pat_wait", 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        applyStimulus("pat_trig", 1'b0, 1'b0, 1'b0, 3'b101, 2'b11, 1'b1);
        readQ.delete(); lastQ.delete();
        for (int k = 0; k < DEPTH; k++) begin
            want[k] = 2'(k % 4);
            applyStimulus("pat_cap", 1'b0, 1'b0, 1'b0, 3'b000, want[k], 1'b1);
        end
        drain("pat_read", 1'b0, 20);
        checkReadout("pat", want);

        // Edge trigger: data_in counts from the trigger edge, holdoff skips one sample.
        applyStimulus("edge_rst", 1'b1, 1'b0, 1'b0, 3'b001, 2'b00, 1'b1);
        applyStimulus("edge_arm", 1'b0, 1'b1, 1'b1, 3'b001, 2'b00, 1'b1);
        applyStimulus("edge_hi", 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 1'b1);
        readQ.delete(); lastQ.delete();
        ledBCount = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus("edge_run", 1'b0, 1'b0, 1'b0, 3'b000, 2'(k), 1'b1);
            if (led_b) ledBCount++;
        end
        compareVal("edge_ledb_cycles", ledBCount, HOLD + DEPTH);
        for (int k = 0; k < DEPTH; k++) want[k] = 2'(k + 1 + HOLD);
        drain("edge_read", 1'b0, 20);
        checkReadout("edge", want);

        // Edge mode with ch8 already low never triggers.
        applyStimulus("nofe_arm", 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, 1'b1);
        for (int k = 0; k < 20; k++) applyStimulus("nofe_hold", 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 1'b1);
        compareVal("nofe_led_r", int'(led_r), 1);
        compareVal("nofe_valid", int'(rd_valid), 0);

        // Backpressure during readout.
        applyStimulus("bp_rst", 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0);
        applyStimulus("bp_arm", 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
        applyStimulus("bp_trig", 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0);
        readQ.delete(); lastQ.delete();
        for (int k = 0; k < DEPTH; k++) begin
            want[k] = 2'((k * 3 + 1) % 4);
            applyStimulus("bp_cap", 1'b0, 1'b0, 1'b0, 3'b000, want[k], 1'b0);
        end
        drain("bp_read", 1'b1, 60);
        checkReadout("bp", want);

        // Re-arm after three reads, then a fresh full capture.
        applyStimulus("rearm_arm", 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
        applyStimulus("rearm_trig", 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0);
        for (int k = 0; k < DEPTH; k++) applyStimulus("rearm_cap1", 1'b0, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus("rearm_read3", 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        applyStimulus("rearm_pulse", 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1);
        compareVal("rearm_valid", int'(rd_valid), 0);
        compareVal("rearm_led_r", int'(led_r), 1);
        applyStimulus("rearm_trig2", 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b1);
        readQ.delete(); lastQ.delete();
        for (int k = 0; k < DEPTH; k++) begin
            want[k] = 2'(3 - (k % 4));
            applyStimulus("rearm_cap2", 1'b0, 1'b0, 1'b0, 3'b000, want[k], 1'b1);
        end
        drain("rearm_read", 1'b0, 20);
        checkReadout("rearm", want);

        // Reset on the 4th capture edge, then a pattern without arm does nothing.
        applyStimulus("rstcap_arm", 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1);
        applyStimulus("rstcap_trig", 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus("rstcap_cap", 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 1'b1);
        applyStimulus("rstcap_rst", 1'b1, 1'b0, 1'b0, 3'b000, 2'b01, 1'b1);
        compareVal("rstcap_outputs", int'(dutOut()), 0);
        for (int k = 0; k < 5; k++) applyStimulus("rstcap_noarm", 1'b0, 1'b0, 1'b0, 3'b101, 2'b10, 1'b1);
        compareVal("rstcap_busy", int'(busy), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus("rand", ($urandom_range(0, 299) == 0), ($urandom_range(0, 14) == 0),
                          1'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Downstream consumer of the trigger pattern generator's outputs.
- Watches the three trigger channels (ch6..ch8) for either a fixed pattern or a falling edge on ch8.
- Once triggered, samples the two data channels (ch3/ch4) for DEPTH consecutive clocks into an internal buffer.
- After capture, replays the buffer over a valid/ready read port to the on-board UART/debug stage, and drives RGB status LEDs.

Parameters:
- DEPTH, 9: number of samples captured per trigger (1..64).
- PATTERN, 3'b101: trigger pattern, compared as {ch6, ch7, ch8} = trig_in[2:0].
- EDGE_HOLDOFF, 1: clocks skipped between the detected ch8 falling edge and the first sample (edge mode only; 0..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- arm  in  1  single-cycle arm pulse (debounced sw2 rising edge).
- mode  in  1  0 = pattern trigger, 1 = ch8 falling-edge trigger; sampled only on arm.
- trig_in  in  3  {ch6, ch7, ch8}.
- data_in  in  2  {ch3, ch4}.
- rd_valid  out  1  buffer entry available.
- rd_data  out  2  current entry, capture order, {ch3, ch4}.
- rd_last  out  1  high with the final entry.
- rd_ready  in  1  consumer accepts entry.
- busy  out  1  high in any state except IDLE.
- led_r  out  1  ARMED indicator (active-high; inversion done at top level).
- led_g  out  1  DONE indicator.
- led_b  out  1  HOLDOFF/CAPTURE indicator.

Behaviour:
- States: IDLE, ARMED, HOLDOFF, CAPTURE, DONE.
- Reset (rst=1 at posedge): state=IDLE, all outputs 0, counters 0, edge-history register 0. Buffer contents undefined. Reset mid-capture or mid-readout aborts with no partial output.
- IDLE: on arm=1, latch mode into mode_q, load trig_prev <= trig_in[0], go to ARMED.
- ARMED, pattern mode: trigger when trig_in == PATTERN at a posedge. Evaluation begins the first cycle after arm. A pattern already present at that cycle triggers immediately.
- ARMED, edge mode: trigger when trig_prev=1 and trig_in[0]=0. trig_prev updates every cycle in ARMED.
- Trigger at edge t, pattern mode: go directly to CAPTURE. Samples are taken at edges t+1 .. t+DEPTH.
- Trigger at edge t, edge mode with EDGE_HOLDOFF=0: go directly to CAPTURE, same sample timing as pattern mode.
- Trigger at edge t, edge mode with EDGE_HOLDOFF>0: go to HOLDOFF for EDGE_HOLDOFF cycles. Samples are taken at edges t+1+EDGE_HOLDOFF .. t+EDGE_HOLDOFF+DEPTH.
- CAPTURE: each cycle write data_in to buf[wr_ptr] and increment wr_ptr. Trigger inputs are ignored. After writing entry DEPTH-1, go to DONE with rd_ptr=0.
- DONE: rd_valid=1 and rd_data=buf[rd_ptr] (registered, valid the cycle DONE is entered). rd_last=1 when rd_ptr==DEPTH-1.
- DONE handshake: on rd_valid & rd_ready, rd_ptr advances. rd_data must hold stable while rd_ready=0. Transfer with rd_last goes to IDLE; rd_valid drops the next cycle.
- arm while ARMED/HOLDOFF/CAPTURE: ignored.
- arm while DONE: discard the remaining buffer, drop rd_valid next cycle, re-enter ARMED with the new mode. arm takes priority over a same-cycle rd transfer.
- Pointer and counter widths are $clog2(DEPTH+1). No wrap: pointers reset to 0 on entry to ARMED.
- busy = (state != IDLE).
- led_r = ARMED, led_b = HOLDOFF|CAPTURE, led_g = DONE; all registered from state.

Test Plan:
- Pattern trigger: arm (mode=0), hold trig_in=3'b000 for 5 clk, then 3'b101 at edge t; drive data_in = 2'b00,01,10,11,00,01,10,11,00 at edges t+1..t+9. Required: readout with rd_ready=1 returns exactly those 9 values in order, rd_last on the 9th, then IDLE.
- Edge trigger: arm (mode=1), ch8 1→0 at edge t, data_in counter from t+1. Required: first captured value is the one at t+2 (EDGE_HOLDOFF=1); led_b high t+1..t+10.
- No false edge: arm (mode=1) with ch8 already 0 and held 0 for 20 clk. Required: stays ARMED, led_r=1, rd_valid=0.
- Backpressure: during readout toggle rd_ready 1,0,0,1… Required: rd_data stable while rd_ready=0, no dropped or duplicated entries, 9 transfers total.
- Re-arm in DONE: after 3 of 9 reads pulse arm. Required: rd_valid=0 next cycle, state ARMED; a new trigger yields a full fresh 9-sample capture.
- Reset mid-capture: assert rst at the 4th CAPTURE cycle. Required: next cycle all outputs 0, state IDLE; a pattern match without arm causes no capture.
